// File: rtl/fc_layer_seq.sv
// Time-multiplexed fully-connected layer: LANES products per beat for all CO neurons, then bias + saturate.
// Optional macro FC_RELU_EN clamps negative saturated outputs to zero in the bias stage.
module fc_layer_seq #(
    parameter int IN_VEC  = 48,
    parameter int CO      = 3,
    parameter int LANES   = 8,
    parameter int IN_BW   = 8,
    parameter int W_BW    = 7,
    parameter int BIAS_BW = 6,
    parameter int OUT_BW  = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         i_in_valid,
    output logic                         o_in_ready,
    input  logic [IN_VEC*IN_BW-1:0]      i_in_fmap,
    output logic                         o_ot_valid,
    input  logic                         i_ot_ready,
    output logic [CO*OUT_BW-1:0]         o_ot_data,
    input  logic                         i_cfg_we,
    input  logic                         i_cfg_bias_we,
    input  logic [$clog2(CO*IN_VEC)-1:0] i_cfg_addr,
    input  logic [W_BW-1:0]              i_cfg_data,
    output logic                         o_cfg_busy
);

    localparam int MUL_BW = IN_BW + W_BW;
    localparam int ACC_BW = MUL_BW + $clog2(IN_VEC) + 1;
    localparam int N_BEAT = IN_VEC / LANES;
    localparam int BEAT_W = (N_BEAT > 1) ? $clog2(N_BEAT) : 1;
    localparam int ADDR_W = $clog2(CO * IN_VEC);
    localparam int SUM_BW = (ACC_BW + 1 > OUT_BW + 1) ? ACC_BW + 1 : OUT_BW + 1;

    localparam logic signed [SUM_BW-1:0] SAT_MAX = {{(SUM_BW-OUT_BW+1){1'b0}}, {(OUT_BW-1){1'b1}}};
    localparam logic signed [SUM_BW-1:0] SAT_MIN = {{(SUM_BW-OUT_BW+1){1'b1}}, {(OUT_BW-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_BIAS = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   cfg_idle;

    logic [LANES*W_BW-1:0]     w_mem  [CO][N_BEAT];
    logic [LANES*IN_BW-1:0]    fmap_q [N_BEAT];
    logic signed [BIAS_BW-1:0] bias_q [CO];
    logic [BEAT_W-1:0]         beat_q;

    logic signed [MUL_BW-1:0]  prod;
    logic signed [ACC_BW-1:0]  beat_sum [CO];
    logic signed [ACC_BW-1:0]  acc_p0   [CO];
    logic signed [SUM_BW-1:0]  sum_p1   [CO];
    logic signed [OUT_BW-1:0]  res_p1   [CO];
    logic [CO*OUT_BW-1:0]      ot_data_p1;
    logic                      vld_p1;

    function automatic logic signed [OUT_BW-1:0] sat_out(input logic signed [SUM_BW-1:0] v);
        if (v > SAT_MAX)
            return SAT_MAX[OUT_BW-1:0];
        else if (v < SAT_MIN)
            return SAT_MIN[OUT_BW-1:0];
        else
            return v[OUT_BW-1:0];
    endfunction

    function automatic logic signed [OUT_BW-1:0] act_out(input logic signed [OUT_BW-1:0] v);
`ifdef FC_RELU_EN
        return v[OUT_BW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    generate
        if (W_BW > BIAS_BW) begin : g_cfg_hi
            logic cfg_data_hi_unused;
            assign cfg_data_hi_unused = ^i_cfg_data[W_BW-1:BIAS_BW];
        end
    endgenerate

    // FSM: next state and state-decoded outputs
    always_comb begin
        state_d    = state_q;
        cfg_idle   = (state_q == S_IDLE);
        o_in_ready = (state_q == S_IDLE);
        o_cfg_busy = (state_q != S_IDLE);
        case (state_q)
            S_IDLE:  if (i_in_valid) state_d = S_ACC;
            S_ACC:   if (beat_q == BEAT_W'(N_BEAT - 1)) state_d = S_BIAS;
            S_BIAS:  state_d = S_OUT;
            S_OUT:   if (i_ot_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Weight RAM and latched feature vector keep no reset; bias/accumulators do.
    always_ff @(posedge clk) begin
        if (cfg_idle && i_cfg_we) begin
            for (int c = 0; c < CO; c++) begin
                for (int b = 0; b < N_BEAT; b++) begin
                    for (int j = 0; j < LANES; j++) begin
                        if (i_cfg_addr == ADDR_W'(c*IN_VEC + b*LANES + j))
                            w_mem[c][b][j*W_BW +: W_BW] <= i_cfg_data;
                    end
                end
            end
        end
        if (cfg_idle && i_in_valid) begin
            for (int b = 0; b < N_BEAT; b++)
                fmap_q[b] <= i_in_fmap[b*LANES*IN_BW +: LANES*IN_BW];
        end
    end

    // Stage p0: one beat of LANES products per neuron
    always_comb begin
        prod = '0;
        for (int c = 0; c < CO; c++) begin
            beat_sum[c] = '0;
            for (int j = 0; j < LANES; j++) begin
                prod = MUL_BW'(signed'(fmap_q[beat_q][j*IN_BW +: IN_BW]))
                     * MUL_BW'(signed'(w_mem[c][beat_q][j*W_BW +: W_BW]));
                beat_sum[c] = beat_sum[c] + ACC_BW'(prod);
            end
        end
    end

    // Stage p1: bias add, saturate, optional activation
    always_comb begin
        for (int c = 0; c < CO; c++) begin
            sum_p1[c] = SUM_BW'(acc_p0[c]) + SUM_BW'(bias_q[c]);
            res_p1[c] = act_out(sat_out(sum_p1[c]));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            beat_q     <= '0;
            vld_p1     <= 1'b0;
            ot_data_p1 <= '0;
            for (int c = 0; c < CO; c++) begin
                acc_p0[c] <= '0;
                bias_q[c] <= '0;
            end
        end else begin
            state_q <= state_d;
            // A simultaneous weight strobe takes priority over the bias strobe.
            if (cfg_idle && i_cfg_bias_we && !i_cfg_we) begin
                for (int c = 0; c < CO; c++) begin
                    if (i_cfg_addr == ADDR_W'(c))
                        bias_q[c] <= i_cfg_data[BIAS_BW-1:0];
                end
            end
            case (state_q)
                S_IDLE: begin
                    if (i_in_valid) begin
                        beat_q <= '0;
                        for (int c = 0; c < CO; c++)
                            acc_p0[c] <= '0;
                    end
                end
                S_ACC: begin
                    beat_q <= beat_q + BEAT_W'(1);
                    for (int c = 0; c < CO; c++)
                        acc_p0[c] <= acc_p0[c] + beat_sum[c];
                end
                S_BIAS: begin
                    for (int c = 0; c < CO; c++)
                        ot_data_p1[c*OUT_BW +: OUT_BW] <= res_p1[c];
                    vld_p1 <= 1'b1;
                end
                S_OUT: begin
                    if (i_ot_ready)
                        vld_p1 <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign o_ot_valid = vld_p1;
    assign o_ot_data  = ot_data_p1;

endmodule

// File: tb/tb_fc_layer_seq.sv
// Self-checking bench for fc_layer_seq: uniform-weight vector table, hand sequences, random back-to-back run.
module tb_fc_layer_seq;
    localparam int IN_VEC = 48, CO = 3, LANES = 8, IN_BW = 8, W_BW = 7, BIAS_BW = 6, OUT_BW = 16;
    localparam int N_BEAT = IN_VEC / LANES;
    localparam int ADDR_W = $clog2(CO * IN_VEC);
`ifdef FC_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b0;
    logic                     i_in_valid = 1'b0;
    logic                     o_in_ready;
    logic [IN_VEC*IN_BW-1:0]  i_in_fmap = '0;
    logic                     o_ot_valid;
    logic                     i_ot_ready = 1'b1;
    logic [CO*OUT_BW-1:0]     o_ot_data;
    logic                     i_cfg_we = 1'b0;
    logic                     i_cfg_bias_we = 1'b0;
    logic [ADDR_W-1:0]        i_cfg_addr = '0;
    logic [W_BW-1:0]          i_cfg_data = '0;
    logic                     o_cfg_busy;

    fc_layer_seq #(
        .IN_VEC(IN_VEC), .CO(CO), .LANES(LANES), .IN_BW(IN_BW),
        .W_BW(W_BW), .BIAS_BW(BIAS_BW), .OUT_BW(OUT_BW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_fmap(i_in_fmap),
        .o_ot_valid(o_ot_valid), .i_ot_ready(i_ot_ready), .o_ot_data(o_ot_data),
        .i_cfg_we(i_cfg_we), .i_cfg_bias_we(i_cfg_bias_we),
        .i_cfg_addr(i_cfg_addr), .i_cfg_data(i_cfg_data), .o_cfg_busy(o_cfg_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    int w_m [CO*IN_VEC];
    int b_m [CO];

    typedef struct {
        logic [CO*OUT_BW-1:0] exp;
        int                   hs;
    } sb_t;
    sb_t q[$];

    typedef struct {
        int w;
        int b;
        int x;
        int exp;
    } vec_t;
    vec_t tbl[6];

    function automatic logic [CO*OUT_BW-1:0] model_out(input logic [IN_VEC*IN_BW-1:0] f);
        logic [CO*OUT_BW-1:0]    r;
        longint                  s;
        longint                  mx;
        logic signed [IN_BW-1:0] x;
        r  = '0;
        mx = (longint'(1) <<< (OUT_BW - 1)) - 1;
        for (int c = 0; c < CO; c++) begin
            s = b_m[c];
            for (int k = 0; k < IN_VEC; k++) begin
                x = f[k*IN_BW +: IN_BW];
                s = s + longint'(x) * longint'(w_m[c*IN_VEC + k]);
            end
            if (s > mx) s = mx;
            if (s < -mx - 1) s = -mx - 1;
            if (RELU && s < 0) s = 0;
            r[c*OUT_BW +: OUT_BW] = s[OUT_BW-1:0];
        end
        return r;
    endfunction

    task automatic chk(input string nm, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    // Scoreboard / protocol monitor, sampled on the falling edge.
    logic                 prev_valid = 1'b0;
    logic                 prev_ready = 1'b0;
    logic [CO*OUT_BW-1:0] prev_data  = '0;
    bit                   drop_chk   = 1'b0;
    always @(negedge clk) begin
        sb_t e;
        if (o_ot_valid === 1'b1 && prev_valid !== 1'b1) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL spurious_valid: got valid=1 at cycle %0d, required no output", cyc);
            end else if (cyc - q[0].hs != N_BEAT + 1) begin
                n_err++;
                $display("FAIL latency: got %0d cycles, required %0d", cyc - q[0].hs, N_BEAT + 1);
            end
        end
        if (o_ot_valid === 1'b1 && prev_valid === 1'b1 && prev_ready === 1'b0) begin
            n_cmp++;
            if (o_ot_data !== prev_data || o_in_ready !== 1'b0 || o_cfg_busy !== 1'b1) begin
                n_err++;
                $display("FAIL hold: got data=%h in_ready=%b busy=%b, required data=%h in_ready=0 busy=1",
                         o_ot_data, o_in_ready, o_cfg_busy, prev_data);
            end
        end
        if (drop_chk) begin
            drop_chk = 1'b0;
            n_cmp++;
            if (o_ot_valid !== 1'b0 || o_in_ready !== 1'b1 || o_cfg_busy !== 1'b0) begin
                n_err++;
                $display("FAIL after_handshake: got valid=%b in_ready=%b busy=%b, required 0 1 0",
                         o_ot_valid, o_in_ready, o_cfg_busy);
            end
        end
        if (o_ot_valid === 1'b1 && i_ot_ready === 1'b1 && q.size() > 0) begin
            e = q.pop_front();
            n_cmp++;
            if (o_ot_data !== e.exp) begin
                n_err++;
                $display("FAIL out_data: got %h, required %h", o_ot_data, e.exp);
            end
            drop_chk = 1'b1;
        end
        prev_valid = o_ot_valid;
        prev_ready = i_ot_ready;
        prev_data  = o_ot_data;
    end

    task automatic cfg_w(input int addr, input int data, input bit bias, input bit taken);
        @(posedge clk); #1;
        i_cfg_we      = !bias;
        i_cfg_bias_we = bias;
        i_cfg_addr    = addr[ADDR_W-1:0];
        i_cfg_data    = data[W_BW-1:0];
        if (taken) begin
            if (bias) b_m[addr] = data;
            else      w_m[addr] = data;
        end
        @(posedge clk); #1;
        i_cfg_we      = 1'b0;
        i_cfg_bias_we = 1'b0;
    endtask

    task automatic send_vec(input logic [IN_VEC*IN_BW-1:0] f, input bit use_tbl, input int texp,
                            output int hs);
        sb_t              e;
        int               t;
        logic [OUT_BW-1:0] t16;
        @(posedge clk); #1;
        i_in_fmap  = f;
        i_in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (o_in_ready !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got in_ready=%b after %0d cycles, required 1", o_in_ready, t);
            i_in_valid = 1'b0;
            hs = -1;
            return;
        end
        @(posedge clk);
        t16   = texp[OUT_BW-1:0];
        e.exp = use_tbl ? {CO{t16}} : model_out(f);
        #1;
        e.hs = cyc;
        q.push_back(e);
        i_in_valid = 1'b0;
        hs = cyc;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(o_in_ready === 1'b1 && q.size() == 0) && t < 500);
        if (t >= 500) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_timeout: got in_ready=%b pending=%0d, required idle", o_in_ready, q.size());
        end
    endtask

    task automatic load_uniform(input int w, input int b);
        for (int a = 0; a < CO*IN_VEC; a++) cfg_w(a, w, 1'b0, 1'b1);
        for (int c = 0; c < CO; c++) cfg_w(c, b, 1'b1, 1'b1);
    endtask

    task automatic load_random();
        for (int a = 0; a < CO*IN_VEC; a++) cfg_w(a, int'($urandom_range(0, 127)) - 64, 1'b0, 1'b1);
        for (int c = 0; c < CO; c++) cfg_w(c, int'($urandom_range(0, 63)) - 32, 1'b1, 1'b1);
    endtask

    function automatic logic [IN_VEC*IN_BW-1:0] rand_fmap();
        logic [IN_VEC*IN_BW-1:0] f;
        for (int k = 0; k < IN_VEC; k++) f[k*IN_BW +: IN_BW] = IN_BW'($urandom);
        return f;
    endfunction

    initial begin
        #500_000;
        $display("FAIL watchdog: got no completion, required end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IN_VEC*IN_BW-1:0] f;
        logic [IN_BW-1:0]        x8;
        int hs, hs_a, hs_b, prev_hs;
        sb_t e;

        tbl[0] = '{1, 0, 1, 48};
        tbl[1] = '{-64, 0, -128, 32767};
        tbl[2] = '{63, 0, -128, RELU ? 0 : -32768};
        tbl[3] = '{2, 5, 3, 293};
        tbl[4] = '{-1, -20, 10, RELU ? 0 : -500};
        tbl[5] = '{0, 31, -77, 31};
        for (int c = 0; c < CO; c++) b_m[c] = 0;

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("reset_valid", o_ot_valid, 0);
        chk("reset_in_ready", o_in_ready, 1);
        chk("reset_busy", o_cfg_busy, 0);
        chk("reset_data", o_ot_data, 0);

        for (int i = 0; i < 6; i++) begin
            wait_idle();
            load_uniform(tbl[i].w, tbl[i].b);
            x8 = IN_BW'(tbl[i].x);
            f  = {IN_VEC{x8}};
            send_vec(f, 1'b1, tbl[i].exp, hs);
        end

        // Backpressure: second vector waits for the output handshake.
        wait_idle();
        load_random();
        cfg_w(0, -3, 1'b0, 1'b1);
        i_ot_ready = 1'b0;
        send_vec(rand_fmap(), 1'b0, 0, hs_a);
        fork
            send_vec(rand_fmap(), 1'b0, 0, hs_b);
            begin
                wait (o_ot_valid === 1'b1);
                repeat (5) @(posedge clk);
                #1 i_ot_ready = 1'b1;
            end
        join
        chk("backpressure_accept", hs_b - hs_a, N_BEAT + 8);

        // Weight write during ACC is dropped; the same write in IDLE lands.
        wait_idle();
        f = rand_fmap();
        f[IN_BW-1:0] = 8'd100;
        send_vec(f, 1'b0, 0, hs);
        cfg_w(0, 5, 1'b0, 1'b0);
        send_vec(f, 1'b0, 0, hs);
        wait_idle();
        cfg_w(0, 5, 1'b0, 1'b1);
        cfg_w(CO*IN_VEC, 9, 1'b0, 1'b0);
        cfg_w(CO, 9, 1'b1, 1'b0);
        send_vec(f, 1'b0, 0, hs);

        // Bias-only result with zero inputs.
        wait_idle();
        cfg_w(0, 0, 1'b1, 1'b1);
        cfg_w(1, -7, 1'b1, 1'b1);
        cfg_w(2, 0, 1'b1, 1'b1);
        send_vec('0, 1'b0, 0, hs);
        wait_idle();
        chk("bias_neg7", $signed(o_ot_data[OUT_BW +: OUT_BW]), RELU ? 0 : -7);

        // Config write and input handshake on the same edge.
        wait_idle();
        f = rand_fmap();
        f[IN_BW +: IN_BW] = 8'd100;
        @(posedge clk); #1;
        i_cfg_we   = 1'b1;
        i_cfg_addr = ADDR_W'(1);
        i_cfg_data = W_BW'(-50);
        w_m[1]     = -50;
        i_in_fmap  = f;
        i_in_valid = 1'b1;
        @(posedge clk);
        e.exp = model_out(f);
        #1;
        e.hs = cyc;
        q.push_back(e);
        i_in_valid = 1'b0;
        i_cfg_we   = 1'b0;

        // Reset mid-accumulation aborts the vector and clears biases.
        wait_idle();
        cfg_w(0, 7, 1'b1, 1'b1);
        cfg_w(1, -9, 1'b1, 1'b1);
        cfg_w(2, 12, 1'b1, 1'b1);
        send_vec(rand_fmap(), 1'b0, 0, hs);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        q.delete();
        for (int c = 0; c < CO; c++) b_m[c] = 0;
        @(negedge clk);
        chk("abort_data", o_ot_data, 0);
        chk("abort_in_ready", o_in_ready, 1);
        chk("abort_valid", o_ot_valid, 0);
        repeat (N_BEAT + 4) @(negedge clk);
        send_vec('0, 1'b0, 0, hs);
        send_vec(rand_fmap(), 1'b0, 0, hs);

        // Random back-to-back run.
        wait_idle();
        load_random();
        prev_hs = -1;
        for (int i = 0; i < 100; i++) begin
            send_vec(rand_fmap(), 1'b0, 0, hs);
            if (i > 0) chk("period", hs - prev_hs, N_BEAT + 3);
            prev_hs = hs;
        end
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
